// File: rtl/pc_pipeline_pkg.sv
// pc_pipeline_pkg: shared defaults, hold-counter width and per-stage action codes
package pc_pipeline_pkg;

    localparam int PC_WIDTH_DEF = 32;
    localparam int PC_DEPTH_DEF = 3;
    localparam int PC_INC_DEF   = 4;
    localparam int HOLD_CNT_W   = 4;

    localparam logic [1:0] ACT_LOAD  = 2'd0;
    localparam logic [1:0] ACT_CLEAR = 2'd1;
    localparam logic [1:0] ACT_HOLD  = 2'd2;

endpackage

// File: rtl/pc_pipe_stage.sv
// pc_pipe_stage: one PC + valid register driven by a per-cycle action code
module pc_pipe_stage
    import pc_pipeline_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       act,
    input  logic [WIDTH-1:0] pc_d,
    input  logic             valid_d,
    output logic [WIDTH-1:0] pc_q,
    output logic             valid_q
);

    // load, clear or keep the stage contents; HOLD falls through and keeps state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else if (act == ACT_LOAD) begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end else if (act == ACT_CLEAR) begin
            pc_q    <= '0;
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_pipeline_param.sv
// pc_pipeline_param: DEPTH-stage PC pipeline with stall, partial flush and post-flush hold
module pc_pipeline_param
    import pc_pipeline_pkg::*;
#(
    parameter int WIDTH        = PC_WIDTH_DEF,
    parameter int DEPTH        = PC_DEPTH_DEF,
    parameter int FLUSH_STAGES = 2,
    parameter int HOLD_CYCLES  = 1,
    parameter int TAIL_INC     = PC_INC_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       pc_i,
    input  logic                   pc_valid_i,
    input  logic                   stall_i,
    input  logic                   flush_i,
    output logic [DEPTH*WIDTH-1:0] stage_pc_o,
    output logic [DEPTH-1:0]       stage_valid_o,
    output logic [WIDTH-1:0]       tail_pc_o,
    output logic                   hold_o
);

    logic [HOLD_CNT_W-1:0] hold_cnt;
    logic                  hold_act;
    logic [1:0]            act     [DEPTH];
    logic [WIDTH-1:0]      pc_d    [DEPTH];
    logic                  valid_d [DEPTH];
    logic [WIDTH-1:0]      pc_q    [DEPTH];
    logic                  valid_q [DEPTH];

    assign hold_act = hold_cnt != '0;
    assign hold_o   = hold_act;

    // hold window counts down; a flush outside the window restarts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hold_cnt <= '0;
        else if (hold_act)
            hold_cnt <= hold_cnt - 1'b1;
        else if (flush_i)
            hold_cnt <= HOLD_CNT_W'(HOLD_CYCLES);
    end

    // priority decode per stage: hold, flush (young stages only), stall, advance
    always_comb begin
        for (int k = 0; k < DEPTH; k++)
            act[k] = hold_act ? ACT_HOLD :
                     flush_i  ? (k < FLUSH_STAGES ? ACT_CLEAR : ACT_LOAD) :
                     stall_i  ? ACT_HOLD : ACT_LOAD;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign pc_d[i]    = pc_i;
            assign valid_d[i] = pc_valid_i;
        end else if (i == DEPTH - 1) begin : g_tail
            assign pc_d[i]    = pc_q[i-1] + WIDTH'(TAIL_INC);
            assign valid_d[i] = valid_q[i-1];
        end else begin : g_mid
            assign pc_d[i]    = pc_q[i-1];
            assign valid_d[i] = valid_q[i-1];
        end

        pc_pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .act     (act[i]),
            .pc_d    (pc_d[i]),
            .valid_d (valid_d[i]),
            .pc_q    (pc_q[i]),
            .valid_q (valid_q[i])
        );

        assign stage_pc_o[i*WIDTH +: WIDTH] = pc_q[i];
        assign stage_valid_o[i]             = valid_q[i];
    end

    assign tail_pc_o = pc_q[DEPTH-1];

endmodule

// File: tb/tb_pc_pipeline_param.sv
// tb_pc_pipeline_param: directed vectors with a queue scoreboard for default and 5-stage configs
module tb_pc_pipeline_param;

    logic         clk = 1'b0;
    logic         rst_n, rst5_n;
    logic [31:0]  pc, pc5;
    logic         pv, st, fl, pv5, st5, fl5;
    logic [95:0]  spc;
    logic [2:0]   sv;
    logic [31:0]  tl;
    logic         hd;
    logic [159:0] spc5;
    logic [4:0]   sv5;
    logic [31:0]  tl5;
    logic         hd5;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit           sel;
        string        name;
        logic [159:0] pcs;
        logic [4:0]   v;
        logic [31:0]  tail;
        logic         h;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    pc_pipeline_param dut (
        .clk(clk), .rst_n(rst_n), .pc_i(pc), .pc_valid_i(pv), .stall_i(st), .flush_i(fl),
        .stage_pc_o(spc), .stage_valid_o(sv), .tail_pc_o(tl), .hold_o(hd)
    );

    pc_pipeline_param #(.DEPTH(5), .FLUSH_STAGES(3), .HOLD_CYCLES(0)) dut5 (
        .clk(clk), .rst_n(rst5_n), .pc_i(pc5), .pc_valid_i(pv5), .stall_i(st5), .flush_i(fl5),
        .stage_pc_o(spc5), .stage_valid_o(sv5), .tail_pc_o(tl5), .hold_o(hd5)
    );

    task automatic cmp(input string nm, input logic [159:0] a, input logic [159:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic step(input bit sel, input logic [31:0] p, input logic v, input logic s,
                        input logic f, input bit chk, input string nm, input logic [159:0] pcs,
                        input logic [4:0] ev, input logic [31:0] et, input logic eh);
        exp_t e;
        @(negedge clk);
        if (sel) begin
            pc5 = p; pv5 = v; st5 = s; fl5 = f;
        end else begin
            pc = p; pv = v; st = s; fl = f;
        end
        if (chk) begin
            e.sel = sel; e.name = nm; e.pcs = pcs; e.v = ev; e.tail = et; e.h = eh;
            q.push_back(e);
        end
    endtask

    // monitor: after each edge, compare outputs against the oldest queued expectation
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            if (e.sel) begin
                cmp({e.name, " pcs"},   spc5, e.pcs);
                cmp({e.name, " valid"}, 160'(sv5), 160'(e.v));
                cmp({e.name, " tail"},  160'(tl5), 160'(e.tail));
                cmp({e.name, " hold"},  160'(hd5), 160'(e.h));
            end else begin
                cmp({e.name, " pcs"},   160'(spc), e.pcs);
                cmp({e.name, " valid"}, 160'(sv), 160'(e.v[2:0]));
                cmp({e.name, " tail"},  160'(tl), 160'(e.tail));
                cmp({e.name, " hold"},  160'(hd), 160'(e.h));
            end
        end
    end

    initial begin
        rst_n = 1'b0; rst5_n = 1'b0;
        pc = '0; pv = 1'b0; st = 1'b0; fl = 1'b0;
        pc5 = '0; pv5 = 1'b0; st5 = 1'b0; fl5 = 1'b0;
        #12;
        cmp("reset pcs",   160'(spc), 160'(0));
        cmp("reset valid", 160'(sv),  160'(0));
        cmp("reset tail",  160'(tl),  160'(0));
        cmp("reset hold",  160'(hd),  160'(0));
        rst_n = 1'b1;

        // fill
        step(0, 32'h100, 1, 0, 0, 1, "e1", {32'h4, 32'h0, 32'h100}, 5'b001, 32'h4, 0);
        step(0, 32'h104, 1, 0, 0, 1, "e2", {32'h4, 32'h100, 32'h104}, 5'b011, 32'h4, 0);
        step(0, 32'h108, 1, 0, 0, 1, "e3", {32'h104, 32'h104, 32'h108}, 5'b111, 32'h104, 0);
        // flush then one hold cycle
        step(0, 32'h200, 1, 0, 1, 1, "flush", {32'h108, 32'h0, 32'h0}, 5'b100, 32'h108, 1);
        step(0, 32'h200, 1, 0, 0, 1, "hold", {32'h108, 32'h0, 32'h0}, 5'b100, 32'h108, 0);
        step(0, 32'h200, 1, 0, 0, 1, "post hold", {32'h4, 32'h0, 32'h200}, 5'b001, 32'h4, 0);
        // stream, stall, flush+stall
        step(0, 32'h204, 1, 0, 0, 1, "s1", {32'h4, 32'h200, 32'h204}, 5'b011, 32'h4, 0);
        step(0, 32'h208, 1, 0, 0, 1, "s2", {32'h204, 32'h204, 32'h208}, 5'b111, 32'h204, 0);
        step(0, 32'h20C, 1, 1, 0, 1, "stall1", {32'h204, 32'h204, 32'h208}, 5'b111, 32'h204, 0);
        step(0, 32'h210, 1, 1, 0, 1, "stall2", {32'h204, 32'h204, 32'h208}, 5'b111, 32'h204, 0);
        step(0, 32'h214, 1, 1, 1, 1, "flush+stall", {32'h208, 32'h0, 32'h0}, 5'b100, 32'h208, 1);
        // flush during hold is dropped
        step(0, 32'h218, 1, 0, 1, 1, "flush in hold", {32'h208, 32'h0, 32'h0}, 5'b100, 32'h208, 0);
        step(0, 32'h21C, 1, 0, 0, 1, "no 2nd clear", {32'h4, 32'h0, 32'h21C}, 5'b001, 32'h4, 0);
        // wraparound and bubble increment
        step(0, 32'hFFFFFFFC, 1, 0, 0, 1, "w1", {32'h4, 32'h21C, 32'hFFFFFFFC}, 5'b011, 32'h4, 0);
        step(0, 32'h300, 0, 0, 0, 1, "w2", {32'h220, 32'hFFFFFFFC, 32'h300}, 5'b110, 32'h220, 0);
        step(0, 32'h304, 1, 0, 0, 1, "wrap", {32'h0, 32'h300, 32'h304}, 5'b101, 32'h0, 0);
        step(0, 32'h308, 1, 0, 0, 1, "bubble inc", {32'h304, 32'h304, 32'h308}, 5'b011, 32'h304, 0);

        // five-stage configuration
        @(negedge clk);
        rst5_n = 1'b1;
        step(1, 32'h10, 1, 0, 0, 0, "", '0, '0, '0, 0);
        step(1, 32'h20, 1, 0, 0, 0, "", '0, '0, '0, 0);
        step(1, 32'h30, 1, 0, 0, 0, "", '0, '0, '0, 0);
        step(1, 32'h40, 1, 0, 0, 0, "", '0, '0, '0, 0);
        step(1, 32'h50, 1, 0, 0, 1, "d5 full",
             {32'h14, 32'h20, 32'h30, 32'h40, 32'h50}, 5'b11111, 32'h14, 0);
        step(1, 32'h60, 1, 0, 1, 1, "d5 flush",
             {32'h24, 32'h30, 32'h0, 32'h0, 32'h0}, 5'b11000, 32'h24, 0);
        step(1, 32'h70, 1, 0, 0, 1, "d5 no hold",
             {32'h34, 32'h0, 32'h0, 32'h0, 32'h70}, 5'b10001, 32'h34, 0);
        @(posedge clk);
        #3;
        rst5_n = 1'b0;
        #1;
        cmp("async rst pcs",   spc5, 160'(0));
        cmp("async rst valid", 160'(sv5), 160'(0));
        cmp("async rst tail",  160'(tl5), 160'(0));
        cmp("async rst hold",  160'(hd5), 160'(0));
        @(posedge clk);
        #2;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard drain: got %0d left expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
